audio_sample_packetizer: RTL and testbench



---
 rtl/audio_sample_packetizer.sv | 161 ++++++++++++++++
 tb/tb_audio_sample_packetizer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_packetizer.sv
// HDMI audio sample packet builder: frame FIFO, IEC 60958 frame counter, valid/ready output.
// Optional drop_count port enabled by defining AUDIO_PKT_DROP_COUNT_EN.
module audio_sample_packetizer #(
  parameter int          CHANNELS               = 2,
  parameter int          SAMPLE_WIDTH           = 16,
  parameter int          FIFO_DEPTH             = 8,
  parameter logic [3:0]  SAMPLING_FREQUENCY     = 4'b0000,
  parameter logic [3:0]  WORD_LENGTH            = 4'b0010,
  parameter logic        COPYRIGHT_NOT_ASSERTED = 1'b1
) (
  input  logic                             clk_pixel,
  input  logic                             reset,
  input  logic                             sample_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample,
  output logic                             pkt_valid,
  input  logic                             pkt_ready,
  output logic [23:0]                      header,
  output logic [223:0]                     sub,
  output logic [7:0]                       frame_counter,
  output logic                             overflow
`ifdef AUDIO_PKT_DROP_COUNT_EN
  ,
  output logic [15:0]                      drop_count
`endif
);

  localparam int FW = CHANNELS * SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = SAMPLE_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t        state, state_d;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, wr_en, pop;
  logic [2:0]    n;
  logic [23:0]   hdr_d;
  logic [223:0]  sub_d;
  logic [7:0]    fc_d;
  logic [8:0]    fc_sum;

  function automatic logic cs_bit(input logic [7:0] a, input logic [3:0] chn);
    logic [35:0] cs;
    cs = {WORD_LENGTH, 2'b00, 2'b00, SAMPLING_FREQUENCY, chn, 4'd0, 8'd0,
          2'b00, 3'b000, COPYRIGHT_NOT_ASSERTED, 1'b0, 1'b0};
    return (a < 8'd36) ? cs[a[5:0]] : 1'b0;
  endfunction

  function automatic logic [55:0] mk_sub(input logic [SW-1:0] l,
                                         input logic [SW-1:0] r,
                                         input logic [7:0] a,
                                         input logic [3:0] chl);
    logic [23:0] wl, wr;
    logic        cl, cr;
    wl = 24'(l) << (24 - SW);
    wr = 24'(r) << (24 - SW);
    cl = cs_bit(a, chl + 4'd1);
    cr = cs_bit(a, chl + 4'd2);
    return {^wr ^ cr, cr, 1'b0, 1'b0, ^wl ^ cl, cl, 1'b0, 1'b0, wr, wl};
  endfunction

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign wr_en = sample_valid && !full;

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: if (count != '0 || wr_en) state_d = LOAD;
      LOAD: begin
        pop     = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (pkt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  generate
    if (CHANNELS == 8) begin : g_l1
      always_comb begin
        logic [FW-1:0] frm;
        frm   = mem[rd_ptr];
        n     = 3'd1;
        sub_d = '0;
        for (int j = 0; j < 4; j++)
          sub_d[j*56 +: 56] = mk_sub(frm[(2*j)*SW +: SW],
                                     frm[(2*j+1)*SW +: SW],
                                     frame_counter, 4'(2*j));
        hdr_d = {3'b000, frame_counter == 8'd0, 4'h0, 3'b000, 1'b1,
                 4'hF, 8'h02};
      end
    end else begin : g_l0
      always_comb begin
        logic [FW-1:0] frm;
        logic [8:0]    t;
        logic [7:0]    a;
        logic [3:0]    pres, b;
        n     = (count >= (AW+1)'(4)) ? 3'd4 : 3'(count);
        sub_d = '0;
        pres  = '0;
        b     = '0;
        for (int i = 0; i < 4; i++) begin
          frm     = mem[rd_ptr + AW'(i)];
          t       = {1'b0, frame_counter} + 9'(i);
          a       = (t >= 9'd192) ? 8'(t - 9'd192) : t[7:0];
          pres[i] = 3'(i) < n;
          b[i]    = pres[i] && (a == 8'd0);
          if (pres[i])
            sub_d[i*56 +: 56] = mk_sub(frm[0 +: SW], frm[SW +: SW], a, 4'd0);
        end
        hdr_d = {b, 4'h0, 3'b000, 1'b0, pres, 8'h02};
      end
    end
  endgenerate

  assign fc_sum = {1'b0, frame_counter} + 9'(n);
  assign fc_d   = (fc_sum >= 9'd192) ? 8'(fc_sum - 9'd192) : fc_sum[7:0];

  always_ff @(posedge clk_pixel)
    if (wr_en) mem[wr_ptr] <= sample;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      pkt_valid     <= 1'b0;
      header        <= '0;
      sub           <= '0;
      frame_counter <= '0;
      overflow      <= 1'b0;
    end else begin
      state    <= state_d;
      overflow <= sample_valid && full;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(n);
      count <= count + (AW+1)'(wr_en) - (pop ? (AW+1)'(n) : '0);
      if (pop) begin
        header        <= hdr_d;
        sub           <= sub_d;
        frame_counter <= fc_d;
        pkt_valid     <= 1'b1;
      end else if (state == HOLD && pkt_ready) begin
        pkt_valid <= 1'b0;
      end
    end
  end

`ifdef AUDIO_PKT_DROP_COUNT_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) drop_count <= '0;
    else if (sample_valid && full && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_audio_sample_packetizer.sv
// Randomized bench: 2-ch/16-bit and 8-ch/24-bit packetizers against a queue-based model.
// Covers overflow bursts, backpressure, reset in HOLD and frame counter wrap.
module tb_audio_sample_packetizer;

  typedef logic [191:0] frm_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         sv   [2];
  frm_t         smp  [2];
  logic         rdy  [2];
  logic         vld  [2];
  logic [23:0]  hdr  [2];
  logic [223:0] sbp  [2];
  logic [7:0]   fc   [2];
  logic         ovf  [2];
  logic [15:0]  dcnt [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_sample_packetizer #(
    .CHANNELS(2), .SAMPLE_WIDTH(16), .FIFO_DEPTH(8)
  ) u0 (
    .clk_pixel(clk), .reset(reset), .sample_valid(sv[0]),
    .sample(smp[0][31:0]), .pkt_valid(vld[0]), .pkt_ready(rdy[0]),
    .header(hdr[0]), .sub(sbp[0]), .frame_counter(fc[0]),
    .overflow(ovf[0])
`ifdef AUDIO_PKT_DROP_COUNT_EN
    , .drop_count(dcnt[0])
`endif
  );

  audio_sample_packetizer #(
    .CHANNELS(8), .SAMPLE_WIDTH(24), .FIFO_DEPTH(4)
  ) u1 (
    .clk_pixel(clk), .reset(reset), .sample_valid(sv[1]),
    .sample(smp[1]), .pkt_valid(vld[1]), .pkt_ready(rdy[1]),
    .header(hdr[1]), .sub(sbp[1]), .frame_counter(fc[1]),
    .overflow(ovf[1])
`ifdef AUDIO_PKT_DROP_COUNT_EN
    , .drop_count(dcnt[1])
`endif
  );

`ifndef AUDIO_PKT_DROP_COUNT_EN
  assign dcnt[0] = '0;
  assign dcnt[1] = '0;
`endif

  // model state: 0 idle, 1 loading, 2 holding a packet
  frm_t         q  [2][$];
  int           fcm[2];
  int           ph [2];
  bit           ev [2];
  logic [23:0]  eh [2];
  logic [223:0] es [2];
  bit           eo [2];
  int           dc [2];

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cs(int a, int c);
    logic [3:0] cn;
    logic [3:0] wl;
    cn = 4'(c + 1);
    wl = 4'b0010;
    if (a == 2) return 1'b1;
    if (a >= 20 && a <= 23) return cn[a-20];
    if (a >= 32 && a <= 35) return wl[a-32];
    return 1'b0;
  endfunction

  function automatic logic [23:0] chan(frm_t f, int c, int w);
    frm_t t;
    logic [23:0] v;
    t = f >> (c * w);
    v = t[23:0];
    if (w < 24) v = v & ((24'd1 << w) - 24'd1);
    return v << (24 - w);
  endfunction

  function automatic logic [55:0] mk(logic [23:0] l, logic [23:0] r,
                                     int a, int c);
    bit cl, cr, pl, pr;
    cl = cs(a, c);
    cr = cs(a, c + 1);
    pl = (^l) ^ cl;
    pr = (^r) ^ cr;
    return {pr, cr, 1'b0, 1'b0, pl, cl, 1'b0, 1'b0, r, l};
  endfunction

  task automatic build(int k);
    int   n, a, w;
    frm_t f;
    w = k ? 24 : 16;
    eh[k] = '0;
    es[k] = '0;
    eh[k][7:0] = 8'h02;
    if (k == 0) begin
      n = (q[k].size() < 4) ? q[k].size() : 4;
      for (int i = 0; i < n; i++) begin
        f = q[k].pop_front();
        a = (fcm[k] + i) % 192;
        eh[k][8+i] = 1'b1;
        eh[k][20+i] = (a == 0);
        es[k][i*56 +: 56] = mk(chan(f, 0, w), chan(f, 1, w), a, 0);
      end
    end else begin
      n = 1;
      f = q[k].pop_front();
      eh[k][12] = 1'b1;
      eh[k][11:8] = 4'hF;
      eh[k][20] = (fcm[k] == 0);
      for (int j = 0; j < 4; j++)
        es[k][j*56 +: 56] = mk(chan(f, 2*j, w), chan(f, 2*j+1, w),
                               fcm[k], 2*j);
    end
    fcm[k] = (fcm[k] + n) % 192;
  endtask

  task automatic step(int k, bit rst, bit v, frm_t s, bit r);
    bit full;
    int depth;
    depth = k ? 4 : 8;
    if (rst) begin
      q[k].delete();
      fcm[k] = 0; ph[k] = 0; ev[k] = 0;
      eh[k] = '0; es[k] = '0; eo[k] = 0; dc[k] = 0;
      return;
    end
    full = (q[k].size() == depth);
    if (ph[k] == 2) begin
      if (r) begin ev[k] = 0; ph[k] = 0; end
    end else if (ph[k] == 1) begin
      build(k);
      ev[k] = 1;
      ph[k] = 2;
    end else if (q[k].size() > 0 || (v && !full)) begin
      ph[k] = 1;
    end
    eo[k] = v && full;
    if (eo[k] && dc[k] < 65535) dc[k]++;
    if (v && !full) q[k].push_back(s);
  endtask

  function automatic frm_t rnd_frame(int k);
    frm_t f;
    int   p;
    f = '0;
    p = $urandom_range(0, 7);
    if (k == 0) begin
      if (p == 0) f = '0;
      else if (p == 1) f[31:0] = 32'h8001_1234;
      else f[31:0] = $urandom;
    end else begin
      for (int c = 0; c < 8; c++)
        f[c*24 +: 24] = (p == 0) ? 24'h0 :
                        (p == 1) ? 24'hA00000 + 24'(c) : 24'($urandom);
    end
    return f;
  endfunction

  initial begin
    bit rst;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; smp[k] = '0; rdy[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("valid%0d", k), 256'(vld[k]), 256'(ev[k]));
          check($sformatf("fc%0d", k), 256'(fc[k]), 256'(fcm[k]));
          check($sformatf("ovf%0d", k), 256'(ovf[k]), 256'(eo[k]));
          if (ev[k]) begin
            check($sformatf("hdr%0d", k), 256'(hdr[k]), 256'(eh[k]));
            check($sformatf("sub%0d", k), 256'(sbp[k]), 256'(es[k]));
          end
`ifdef AUDIO_PKT_DROP_COUNT_EN
          check($sformatf("dcnt%0d", k), 256'(dcnt[k]), 256'(dc[k]));
`endif
        end
      end
      rst = (cyc < 2) || (cyc == 1508) || (cyc == 3000);
      reset = rst;
      for (int k = 0; k < 2; k++) begin
        if (cyc >= 1000 && cyc < 1013) begin
          sv[k] = 1'b1; rdy[k] = 1'b0;
        end else if (cyc >= 1013 && cyc < 1030) begin
          sv[k] = 1'b0; rdy[k] = 1'b0;
        end else if (cyc >= 1500 && cyc < 1508) begin
          sv[k] = (cyc == 1500); rdy[k] = 1'b0;
        end else begin
          sv[k] = ($urandom_range(0, 99) < 40);
          rdy[k] = ($urandom_range(0, 99) < 60);
        end
        smp[k] = rnd_frame(k);
        step(k, rst, sv[k], smp[k], rdy[k]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
